mod_vga_timing: RTL and testbench

Consumer end of the 25.175 MHz pixel clock produced by the clock master. Generates 640x480@60 VGA raster timing: horizontal/vertical sync, active-video flag, pixel coordinates and line/frame strobes. Feeds the VGA output pins and the pixel/PPU fetch logic. Fully synchronous to the pixel clock.

---
 rtl/mod_vga_timing_pkg.sv | 31 +++
 rtl/mod_vga_timing_wrap_counter.sv | 29 ++
 rtl/mod_vga_timing.sv | 127 ++++++++++++
 tb/tb_mod_vga_timing.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mod_vga_timing_pkg.sv
// Shared 640x480@60 raster constants and the decoded control bundle.
// Latency: n/a (constants and types only).
// Backpressure: n/a; also imported by the pixel-fetch logic so both sides agree on timing.
package mod_vga_timing_pkg;

    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FRONT  = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BACK   = 48;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FRONT  = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BACK   = 33;

    localparam int VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;
    localparam int VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;

    // Standard VGA syncs are active-low.
    localparam bit VGA_SYNC_ACTIVE = 1'b0;
    localparam int VGA_COORD_W     = 10;

    // Per-position control outputs, registered together with the coordinates.
    typedef struct packed {
        logic hsync;
        logic vsync;
        logic active;
        logic line_start;
        logic frame_start;
    } vga_ctl_t;

endpackage

// File: rtl/mod_vga_timing_wrap_counter.sv
// Modulo-(MAX+1) up-counter with a terminal-count wrap flag for chaining.
// Latency: count updates on the edge after in_inc; out_wrap is combinational.
// Backpressure: holds its value whenever in_inc is low.
module mod_wrap_counter #(
    parameter int MAX = 799,
    parameter int W   = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_inc,
    output logic [W-1:0] out_count,
    output logic         out_wrap
);

    localparam logic [W-1:0] LAST = W'(MAX);

    // Wrap is qualified by in_inc so the next counter in the chain steps exactly once.
    assign out_wrap = in_inc && (out_count == LAST);

    // Count register: step on in_inc, return to zero after LAST.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_count <= '0;
        end else if (in_inc) begin
            out_count <= out_wrap ? '0 : out_count + W'(1);
        end
    end

endmodule

// File: rtl/mod_vga_timing.sv
// VGA raster timing generator: syncs, active flag, coordinates, line/frame strobes.
// Latency: every output is registered and describes the same (x,y); first enabled edge after reset presents (0,0).
// Backpressure: in_enable low freezes position and levels, strobes forced low.
module mod_vga_timing
    import mod_vga_timing_pkg::*;
#(
    parameter int H_ACTIVE    = VGA_H_ACTIVE,
    parameter int H_FRONT     = VGA_H_FRONT,
    parameter int H_SYNC      = VGA_H_SYNC,
    parameter int H_BACK      = VGA_H_BACK,
    parameter int V_ACTIVE    = VGA_V_ACTIVE,
    parameter int V_FRONT     = VGA_V_FRONT,
    parameter int V_SYNC      = VGA_V_SYNC,
    parameter int V_BACK      = VGA_V_BACK,
    parameter bit SYNC_ACTIVE = VGA_SYNC_ACTIVE,
    parameter int COORD_W     = VGA_COORD_W
) (
    input  logic               in_clk_25_175_mhz,
    input  logic               in_rst,
    input  logic               in_enable,
    output logic               out_hsync,
    output logic               out_vsync,
    output logic               out_active,
    output logic [COORD_W-1:0] out_x,
    output logic [COORD_W-1:0] out_y,
    output logic               out_line_start,
    output logic               out_frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [COORD_W-1:0] X_ACT_END = COORD_W'(H_ACTIVE);
    localparam logic [COORD_W-1:0] HS_BEG    = COORD_W'(H_ACTIVE + H_FRONT);
    localparam logic [COORD_W-1:0] HS_END    = COORD_W'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam logic [COORD_W-1:0] Y_ACT_END = COORD_W'(V_ACTIVE);
    localparam logic [COORD_W-1:0] VS_BEG    = COORD_W'(V_ACTIVE + V_FRONT);
    localparam logic [COORD_W-1:0] VS_END    = COORD_W'(V_ACTIVE + V_FRONT + V_SYNC);

    // Coordinates must be representable, otherwise every compare below is meaningless.
    if (H_TOTAL >= (1 << COORD_W) || V_TOTAL >= (1 << COORD_W)) begin : g_bad_coord_w
        $fatal(1, "mod_vga_timing: H_TOTAL/V_TOTAL do not fit in COORD_W bits");
    end

    // primed=0 is the pre-position state after reset: the first enabled edge
    // enters (0,0) instead of advancing the counters.
    logic               primed;
    logic               adv;
    logic               h_wrap;
    logic               v_wrap;
    logic [COORD_W-1:0] x_cnt;
    logic [COORD_W-1:0] y_cnt;
    logic [COORD_W-1:0] x_nxt;
    logic [COORD_W-1:0] y_nxt;
    vga_ctl_t           ctl_nxt;
    vga_ctl_t           ctl_q;

    assign adv = in_enable && primed;

    mod_wrap_counter #(
        .MAX (H_TOTAL - 1),
        .W   (COORD_W)
    ) u_hcnt (
        .clk       (in_clk_25_175_mhz),
        .rst       (in_rst),
        .in_inc    (adv),
        .out_count (x_cnt),
        .out_wrap  (h_wrap)
    );

    mod_wrap_counter #(
        .MAX (V_TOTAL - 1),
        .W   (COORD_W)
    ) u_vcnt (
        .clk       (in_clk_25_175_mhz),
        .rst       (in_rst),
        .in_inc    (h_wrap),
        .out_count (y_cnt),
        .out_wrap  (v_wrap)
    );

    // Position the counters will hold after this edge (only meaningful while enabled).
    always_comb begin
        x_nxt = '0;
        y_nxt = '0;
        if (primed) begin
            x_nxt = h_wrap ? '0 : x_cnt + COORD_W'(1);
            y_nxt = v_wrap ? '0 : (h_wrap ? y_cnt + COORD_W'(1) : y_cnt);
        end
    end

    // Decode the upcoming position so the control register lines up with the counters.
    always_comb begin
        ctl_nxt.active      = (x_nxt < X_ACT_END) && (y_nxt < Y_ACT_END);
        ctl_nxt.hsync       = ((x_nxt >= HS_BEG) && (x_nxt < HS_END)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        ctl_nxt.vsync       = ((y_nxt >= VS_BEG) && (y_nxt < VS_END)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        ctl_nxt.line_start  = (x_nxt == '0);
        ctl_nxt.frame_start = (x_nxt == '0) && (y_nxt == '0);
    end

    // Control register: load on enable, otherwise hold levels and drop strobes.
    always_ff @(posedge in_clk_25_175_mhz or posedge in_rst) begin
        if (in_rst) begin
            primed            <= 1'b0;
            ctl_q.hsync       <= ~SYNC_ACTIVE;
            ctl_q.vsync       <= ~SYNC_ACTIVE;
            ctl_q.active      <= 1'b0;
            ctl_q.line_start  <= 1'b0;
            ctl_q.frame_start <= 1'b0;
        end else if (in_enable) begin
            primed <= 1'b1;
            ctl_q  <= ctl_nxt;
        end else begin
            ctl_q.line_start  <= 1'b0;
            ctl_q.frame_start <= 1'b0;
        end
    end

    assign out_x           = x_cnt;
    assign out_y           = y_cnt;
    assign out_hsync       = ctl_q.hsync;
    assign out_vsync       = ctl_q.vsync;
    assign out_active      = ctl_q.active;
    assign out_line_start  = ctl_q.line_start;
    assign out_frame_start = ctl_q.frame_start;

endmodule

// File: tb/tb_mod_vga_timing.sv
// Bench for mod_vga_timing: default 640x480 instance (a) and a 16x7 override instance (b).
// Expected outputs come from a behavioural raster model, queued per edge and popped after it.
// Directed probes at the timing boundaries compare against fixed constants.
module tb_mod_vga_timing;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, en_a, rst_b, en_b;
    logic hs_a, vs_a, act_a, ls_a, fs_a;
    logic hs_b, vs_b, act_b, ls_b, fs_b;
    logic [9:0] x_a, y_a, x_b, y_b;

    mod_vga_timing u_a (
        .in_clk_25_175_mhz (clk),
        .in_rst            (rst_a),
        .in_enable         (en_a),
        .out_hsync         (hs_a),
        .out_vsync         (vs_a),
        .out_active        (act_a),
        .out_x             (x_a),
        .out_y             (y_a),
        .out_line_start    (ls_a),
        .out_frame_start   (fs_a)
    );

    mod_vga_timing #(
        .H_ACTIVE (8), .H_FRONT (2), .H_SYNC (3), .H_BACK (3),
        .V_ACTIVE (4), .V_FRONT (1), .V_SYNC (1), .V_BACK (1),
        .SYNC_ACTIVE (1'b0), .COORD_W (10)
    ) u_b (
        .in_clk_25_175_mhz (clk),
        .in_rst            (rst_b),
        .in_enable         (en_b),
        .out_hsync         (hs_b),
        .out_vsync         (vs_b),
        .out_active        (act_b),
        .out_x             (x_b),
        .out_y             (y_b),
        .out_line_start    (ls_b),
        .out_frame_start   (fs_b)
    );

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic hs, vs, act, ls, fs;
    } obs_t;

    typedef struct {
        int   x;
        int   y;
        bit   primed;
        obs_t o;
    } mdl_t;

    obs_t oa, ob;
    assign oa = {x_a, y_a, hs_a, vs_a, act_a, ls_a, fs_a};
    assign ob = {x_b, y_b, hs_b, vs_b, act_b, ls_b, fs_b};

    int   checks   = 0;
    int   failures = 0;
    mdl_t ma, mb;
    obs_t qa[$];
    obs_t qb[$];

    // Behavioural raster: position advance, then level/strobe decode of the new position.
    function automatic mdl_t mdl_next(mdl_t m, bit rst, bit en,
                                      int ha, int hf, int hsw, int hb,
                                      int va, int vf, int vsw, int vb);
        mdl_t r;
        int   ht;
        int   vt;
        r  = m;
        ht = ha + hf + hsw + hb;
        vt = va + vf + vsw + vb;
        if (rst) begin
            r.x = 0; r.y = 0; r.primed = 1'b0;
            r.o.x = '0; r.o.y = '0;
            r.o.hs = 1'b1; r.o.vs = 1'b1; r.o.act = 1'b0; r.o.ls = 1'b0; r.o.fs = 1'b0;
        end else if (en) begin
            if (!m.primed) begin
                r.x = 0; r.y = 0; r.primed = 1'b1;
            end else begin
                r.x = m.x + 1;
                if (r.x == ht) begin
                    r.x = 0;
                    r.y = m.y + 1;
                    if (r.y == vt) r.y = 0;
                end
            end
            r.o.x   = 10'(r.x);
            r.o.y   = 10'(r.y);
            r.o.act = (r.x < ha) && (r.y < va);
            r.o.hs  = !((r.x >= ha + hf) && (r.x < ha + hf + hsw));
            r.o.vs  = !((r.y >= va + vf) && (r.y < va + vf + vsw));
            r.o.ls  = (r.x == 0);
            r.o.fs  = (r.x == 0) && (r.y == 0);
        end else begin
            r.o.ls = 1'b0;
            r.o.fs = 1'b0;
        end
        return r;
    endfunction

    task automatic cmp(string tag, obs_t got, obs_t exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got x=%0d y=%0d hs=%b vs=%b act=%b ls=%b fs=%b exp x=%0d y=%0d hs=%b vs=%b act=%b ls=%b fs=%b",
                   tag, got.x, got.y, got.hs, got.vs, got.act, got.ls, got.fs,
                   exp.x, exp.y, exp.hs, exp.vs, exp.act, exp.ls, exp.fs);
        end
    endtask

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // One clock: queue the model's view of the edge, take the edge, compare both instances.
    task automatic cyc(string tag);
        ma = mdl_next(ma, rst_a, en_a, 640, 16, 96, 48, 480, 10, 2, 33);
        mb = mdl_next(mb, rst_b, en_b, 8, 2, 3, 3, 4, 1, 1, 1);
        qa.push_back(ma.o);
        qb.push_back(mb.o);
        @(posedge clk);
        #1;
        cmp({tag, "_a"}, oa, qa.pop_front());
        cmp({tag, "_b"}, ob, qb.pop_front());
    endtask

    // Boundary probes on the small raster against fixed values.
    task automatic probe_b();
        if (mb.x == 9 || mb.x == 13) chk("b_hs_idle", 32'(hs_b), 32'd1);
        if (mb.x >= 10 && mb.x <= 12) chk("b_hs_pulse", 32'(hs_b), 32'd0);
        if (mb.x == 0 && mb.y == 5) chk("b_vs_pulse", 32'(vs_b), 32'd0);
        if (mb.x == 0 && (mb.y == 4 || mb.y == 6)) chk("b_vs_idle", 32'(vs_b), 32'd1);
        if (mb.x == 7 && mb.y == 3) chk("b_act_last", 32'(act_b), 32'd1);
        if (mb.x == 0 && mb.y == 4) chk("b_act_vblank", 32'(act_b), 32'd0);
    endtask

    initial begin
        int cnt;
        int guard;

        ma = '{x: 0, y: 0, primed: 1'b0, o: '0};
        mb = '{x: 0, y: 0, primed: 1'b0, o: '0};
        rst_a = 1'b1; en_a = 1'b1;
        rst_b = 1'b1; en_b = 1'b1;
        #1;
        ma = mdl_next(ma, 1'b1, 1'b1, 640, 16, 96, 48, 480, 10, 2, 33);
        qa.push_back(ma.o);
        cmp("reset_async_a", oa, qa.pop_front());
        chk("reset_hsync", 32'(hs_a), 32'd1);
        for (int i = 0; i < 3; i++) cyc("reset_hold");

        // Release: first edge enters (0,0) with both strobes.
        rst_a = 1'b0; rst_b = 1'b0;
        cyc("first");
        chk("first_x", 32'(x_a), 32'd0);
        chk("first_act", 32'(act_a), 32'd1);
        chk("first_ls", 32'(ls_a), 32'd1);
        chk("first_fs", 32'(fs_a), 32'd1);
        cyc("second");
        chk("second_x", 32'(x_a), 32'd1);
        chk("second_fs", 32'(fs_a), 32'd0);

        // Run a to (100,7) with line-boundary probes on the first two lines.
        guard = 0;
        while (!(ma.x == 100 && ma.y == 7) && guard < 8000) begin
            cyc("run");
            guard++;
            if (ma.y <= 1) begin
                if (ma.x == 639) chk("x639_act", 32'(act_a), 32'd1);
                if (ma.x == 640) chk("x640_act", 32'(act_a), 32'd0);
                if (ma.x == 655) chk("x655_hs", 32'(hs_a), 32'd1);
                if (ma.x == 656) chk("x656_hs", 32'(hs_a), 32'd0);
                if (ma.x == 751) chk("x751_hs", 32'(hs_a), 32'd0);
                if (ma.x == 752) chk("x752_hs", 32'(hs_a), 32'd1);
                if (ma.x == 0 && ma.y == 1) begin
                    chk("wrap_y", 32'(y_a), 32'd1);
                    chk("wrap_ls", 32'(ls_a), 32'd1);
                    chk("wrap_fs", 32'(fs_a), 32'd0);
                    chk("wrap_vs", 32'(vs_a), 32'd1);
                end
            end
        end
        chk("reach_100_7", 32'(guard < 8000), 32'd1);

        // Freeze a for 5 cycles, then resume.
        en_a = 1'b0;
        for (int i = 0; i < 5; i++) cyc("hold_a");
        chk("hold_x", 32'(x_a), 32'd100);
        chk("hold_y", 32'(y_a), 32'd7);
        chk("hold_ls", 32'(ls_a), 32'd0);
        en_a = 1'b1;
        cyc("resume_a");
        chk("resume_x", 32'(x_a), 32'd101);

        // Freeze b on the last position of its frame, then resume into (0,0).
        guard = 0;
        while (!(mb.x == 15 && mb.y == 6) && guard < 300) begin
            cyc("run_b");
            guard++;
        end
        chk("reach_b_end", 32'(guard < 300), 32'd1);
        en_b = 1'b0;
        for (int i = 0; i < 5; i++) cyc("hold_b");
        chk("hold_b_fs", 32'(fs_b), 32'd0);
        en_b = 1'b1;
        cyc("resume_b");
        chk("resume_b_x", 32'(x_b), 32'd0);
        chk("resume_b_y", 32'(y_b), 32'd0);
        chk("resume_b_fs", 32'(fs_b), 32'd1);
        cyc("resume_b2");
        chk("resume_b2_fs", 32'(fs_b), 32'd0);

        // Frame period on b, measured twice between frame_start pulses.
        for (int f = 0; f < 2; f++) begin
            guard = 0;
            while (fs_b !== 1'b1 && guard < 300) begin
                cyc("wait_fs");
                probe_b();
                guard++;
            end
            cnt = 0;
            do begin
                cyc("frame_b");
                probe_b();
                cnt++;
            end while (fs_b !== 1'b1 && cnt < 300);
            chk("frame_period_b", 32'(cnt), 32'd112);
        end

        // Async reset on a mid-cycle at (300, y), no clock edge needed.
        guard = 0;
        while (ma.x != 300 && guard < 1000) begin
            cyc("run_300");
            guard++;
        end
        rst_a = 1'b1;
        #2;
        ma = mdl_next(ma, 1'b1, en_a, 640, 16, 96, 48, 480, 10, 2, 33);
        qa.push_back(ma.o);
        cmp("async_mid_a", oa, qa.pop_front());
        chk("async_x", 32'(x_a), 32'd0);
        chk("async_act", 32'(act_a), 32'd0);
        cyc("async_hold");
        rst_a = 1'b0;
        cyc("restart");
        chk("restart_fs", 32'(fs_a), 32'd1);
        chk("restart_y", 32'(y_a), 32'd0);
        cyc("restart2");
        chk("restart2_x", 32'(x_a), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
